// File: rtl/sec_mask_pkg.sv
// Shared definitions for the masked conversion datapath: default share geometry,
// AND-gadget randomness sizing and the serial converter FSM states.
package sec_mask_pkg;

    localparam int K_WIDTH_DEF  = 32;
    localparam int N_SHARES_DEF = 8;

    function automatic int rand_and(input int n);
        return n * (n - 1) / 2;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } a2b_state_t;

endpackage

// File: rtl/sec_and_dom_bit.sv
// N-share, 1-bit domain-oriented masked AND with one register stage.
// The synchronous clr zeroes the registered terms so the output reads as a zero sharing.
module sec_and_dom_bit
    import sec_mask_pkg::*;
#(
    parameter int N_SHARES = N_SHARES_DEF,
    parameter int RAND_AND = rand_and(N_SHARES)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                clr,
    input  logic [N_SHARES-1:0] a,
    input  logic [N_SHARES-1:0] b,
    input  logic [RAND_AND-1:0] rnd,
    output logic [N_SHARES-1:0] z
);

    // Random bit shared by the (i,j) and (j,i) cross terms, i<j.
    function automatic int pair_idx(input int i, input int j);
        return i * (2 * N_SHARES - i - 1) / 2 + (j - i - 1);
    endfunction

    logic [N_SHARES*N_SHARES-1:0] term_nxt;
    logic [N_SHARES*N_SHARES-1:0] term_q;

    for (genvar gi = 0; gi < N_SHARES; gi++) begin : g_row
        for (genvar gj = 0; gj < N_SHARES; gj++) begin : g_col
            if (gi == gj) begin : g_inner
                assign term_nxt[gi*N_SHARES+gj] = a[gi] & b[gj];
            end else if (gi < gj) begin : g_upper
                assign term_nxt[gi*N_SHARES+gj] = (a[gi] & b[gj]) ^ rnd[pair_idx(gi, gj)];
            end else begin : g_lower
                assign term_nxt[gi*N_SHARES+gj] = (a[gi] & b[gj]) ^ rnd[pair_idx(gj, gi)];
            end
        end
    end

    // Register boundary: cross terms are stored before compression.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            term_q <= '0;
        end else if (ena) begin
            term_q <= clr ? '0 : term_nxt;
        end
    end

    for (genvar gi = 0; gi < N_SHARES; gi++) begin : g_out
        assign z[gi] = ^term_q[gi*N_SHARES +: N_SHARES];
    end

endmodule

// File: rtl/sec_a2b_serial.sv
// Bit-serial arithmetic-to-Boolean masking converter built on one 1-bit DOM AND carry engine.
// Optional macro SEC_A2B_SERIAL_REFRESH_EN enables refreshing of the loaded sharings.
module sec_a2b_serial
    import sec_mask_pkg::*;
#(
    parameter int K_WIDTH  = K_WIDTH_DEF,
    parameter int N_SHARES = N_SHARES_DEF,
    parameter int RAND_AND = rand_and(N_SHARES),
    parameter int RAND_REF = K_WIDTH * (N_SHARES - 1),
    parameter int RNDW     = RAND_REF + RAND_AND
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          dvld,
    input  logic                          ena,
    input  logic [RNDW-1:0]               rnd,
    input  logic [K_WIDTH*N_SHARES-1:0]   i_a,
    output logic [K_WIDTH*N_SHARES-1:0]   o_b,
    output logic                          ovld,
    output logic                          ready
);

    localparam int IDX_W = (N_SHARES > 2) ? $clog2(N_SHARES) : 1;
    localparam int BIT_W = (K_WIDTH > 2) ? $clog2(K_WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SHARES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(K_WIDTH - 1);
`ifdef SEC_A2B_SERIAL_REFRESH_EN
    localparam logic REFRESH_EN = 1'b1;
`else
    localparam logic REFRESH_EN = 1'b0;
`endif

    // Sharing of v as (r_0, ..., r_{N-2}, v ^ XOR r_s); all-zero masks when refresh is off.
    function automatic logic [K_WIDTH*N_SHARES-1:0] refresh_share(
        input logic [K_WIDTH-1:0]  v,
        input logic [RAND_REF-1:0] r
    );
        logic [K_WIDTH*N_SHARES-1:0] sh;
        logic [RAND_REF-1:0]         rm;
        logic [K_WIDTH-1:0]          last;
        rm   = r & {RAND_REF{REFRESH_EN}};
        sh   = '0;
        last = v;
        for (int s = 0; s < N_SHARES - 1; s++) begin
            sh[s*K_WIDTH +: K_WIDTH] = rm[s*K_WIDTH +: K_WIDTH];
            last = last ^ rm[s*K_WIDTH +: K_WIDTH];
        end
        sh[(N_SHARES-1)*K_WIDTH +: K_WIDTH] = last;
        return sh;
    endfunction

    a2b_state_t state_q, state_nxt;

    logic [K_WIDTH-1:0] a_reg [N_SHARES];
    logic [K_WIDTH-1:0] acc   [N_SHARES];
    logic [K_WIDTH-1:0] y_sh  [N_SHARES];
    logic [K_WIDTH-1:0] acc_shift [N_SHARES];
    logic [K_WIDTH*N_SHARES-1:0] acc_shift_flat, acc_init, y_init;
    logic [IDX_W-1:0] idx;
    logic [BIT_W-1:0] bit_cnt;
    logic [N_SHARES-1:0] x_bit, y_bit, c_prev, c_cur, s_bit, and_a, and_b, and_z;
    logic last_bit, last_idx;

    assign acc_init = refresh_share(i_a[K_WIDTH-1:0], rnd[RAND_REF-1:0]);
    assign y_init   = refresh_share(a_reg[idx], rnd[RAND_REF-1:0]);
    assign last_bit = (bit_cnt == BIT_LAST);
    assign last_idx = (idx == IDX_LAST);

    // Carry c_j is rebuilt from the gadget output and the previous carry: c_{j+1} = AND ^ c_j.
    assign c_cur = and_z ^ c_prev;
    assign s_bit = x_bit ^ y_bit ^ c_cur;
    assign and_a = x_bit ^ c_cur;
    assign and_b = y_bit ^ c_cur;

    always_comb begin
        acc_shift_flat = '0;
        for (int s = 0; s < N_SHARES; s++) begin
            x_bit[s]     = acc[s][0];
            y_bit[s]     = y_sh[s][0];
            acc_shift[s] = {s_bit[s], acc[s][K_WIDTH-1:1]};
            acc_shift_flat[s*K_WIDTH +: K_WIDTH] = acc_shift[s];
        end
    end

    sec_and_dom_bit #(
        .N_SHARES (N_SHARES),
        .RAND_AND (RAND_AND)
    ) u_and (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .clr   (state_q == LOAD),
        .a     (and_a),
        .b     (and_b),
        .rnd   (rnd[RNDW-1:RAND_REF]),
        .z     (and_z)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        if (ena) begin
            case (state_q)
                IDLE:    if (dvld) state_nxt = LOAD;
                LOAD:    state_nxt = ADD;
                ADD:     if (last_bit) state_nxt = last_idx ? DONE : LOAD;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        ready = (state_q == IDLE);
        ovld  = (state_q == DONE) && ena;
    end

    // Stage boundary: share, accumulator, carry and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < N_SHARES; s++) begin
                a_reg[s] <= '0;
                acc[s]   <= '0;
                y_sh[s]  <= '0;
            end
            c_prev  <= '0;
            idx     <= '0;
            bit_cnt <= '0;
            o_b     <= '0;
        end else if (ena) begin
            case (state_q)
                IDLE: if (dvld) begin
                    for (int s = 0; s < N_SHARES; s++) begin
                        a_reg[s] <= i_a[s*K_WIDTH +: K_WIDTH];
                        acc[s]   <= acc_init[s*K_WIDTH +: K_WIDTH];
                    end
                    idx <= IDX_W'(1);
                end
                LOAD: begin
                    for (int s = 0; s < N_SHARES; s++) begin
                        y_sh[s] <= y_init[s*K_WIDTH +: K_WIDTH];
                    end
                    c_prev  <= '0;
                    bit_cnt <= '0;
                end
                ADD: begin
                    for (int s = 0; s < N_SHARES; s++) begin
                        acc[s]  <= acc_shift[s];
                        y_sh[s] <= {1'b0, y_sh[s][K_WIDTH-1:1]};
                    end
                    c_prev  <= c_cur;
                    bit_cnt <= bit_cnt + BIT_W'(1);
                    if (last_bit) begin
                        if (last_idx) o_b <= acc_shift_flat;
                        else          idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sec_a2b_serial.sv
// Scoreboard bench for sec_a2b_serial: the reference is the modular sum of the arithmetic shares.
module tb_sec_a2b_serial;

    localparam int K   = 32;
    localparam int N   = 8;
    localparam int RA  = N * (N - 1) / 2;
    localparam int RR  = K * (N - 1);
    localparam int RW  = RR + RA;
    localparam int LAT = (N - 1) * (K + 1);

    typedef struct {
        logic [K-1:0] x;
        int           lat;
        int           acc;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic            dvld;
    logic            ena;
    logic [RW-1:0]   rnd;
    logic [K*N-1:0]  i_a;
    logic [K*N-1:0]  o_b;
    logic            ovld;
    logic            ready;

    exp_t         sb[$];
    exp_t         mon_e;
    logic [K-1:0] ob_xor_exp;
    int           cyc = 0;
    int           total = 0;
    int           bad = 0;
    bit           rnd_zero;

    sec_a2b_serial dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dvld  (dvld),
        .ena   (ena),
        .rnd   (rnd),
        .i_a   (i_a),
        .o_b   (o_b),
        .ovld  (ovld),
        .ready (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [K-1:0] xor_shares(input logic [K*N-1:0] v);
        logic [K-1:0] r;
        r = '0;
        for (int s = 0; s < N; s++) r = r ^ v[s*K +: K];
        return r;
    endfunction

    function automatic logic [K-1:0] sum_shares(input logic [K*N-1:0] v);
        logic [K-1:0] r;
        r = '0;
        for (int s = 0; s < N; s++) r = r + v[s*K +: K];
        return r;
    endfunction

    function automatic logic [K*N-1:0] rand_shares();
        logic [K*N-1:0] v;
        for (int s = 0; s < N; s++) v[s*K +: K] = $urandom;
        return v;
    endfunction

    function automatic logic [K*N-1:0] shares_for(input logic [K-1:0] target);
        logic [K*N-1:0] v;
        v = rand_shares();
        v[(N-1)*K +: K] = '0;
        v[(N-1)*K +: K] = target - sum_shares(v);
        return v;
    endfunction

    function automatic logic [RW-1:0] rand_word();
        logic [255:0] t;
        for (int w = 0; w < 8; w++) t[w*32 +: 32] = $urandom;
        return t[RW-1:0];
    endfunction

    task automatic check(input string name, input logic [K*N-1:0] act, input logic [K*N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Waits for ready, presents one transaction and records its expectation.
    task automatic issue(input logic [K*N-1:0] a, input int exp_lat, output int acc_cyc);
        exp_t e;
        int   w;
        w = 0;
        acc_cyc = -1;
        @(negedge clk);
        while (!ready && w < 1000) begin
            @(negedge clk);
            w++;
        end
        check("accept_timeout", {255'd0, ready}, 1);
        if (ready) begin
            i_a  = a;
            dvld = 1'b1;
            @(posedge clk);
            #1;
            e.x   = sum_shares(a);
            e.lat = exp_lat;
            e.acc = cyc;
            acc_cyc = cyc;
            sb.push_back(e);
            @(negedge clk);
            dvld = 1'b0;
        end
    endtask

    task automatic wait_empty();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        check("done_timeout", {255'd0, sb.size() == 0}, 1);
        sb.delete();
        @(negedge clk);
    endtask

    // Monitor: pops the oldest expectation on every ovld pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ovld) begin
                if (sb.size() == 0) begin
                    check("spurious_ovld", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("ob_xor", {224'd0, xor_shares(o_b)}, {224'd0, mon_e.x});
                    check("latency", (K*N)'(cyc - mon_e.acc), (K*N)'(mon_e.lat));
                    ob_xor_exp = mon_e.x;
                end
            end else begin
                check("ob_hold", {224'd0, xor_shares(o_b)}, {224'd0, ob_xor_exp});
            end
        end
    end

    initial begin
        rnd = '0;
        forever begin
            @(negedge clk);
            rnd = rnd_zero ? '0 : rand_word();
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [K*N-1:0] v;
        int a1, a2;
        rst_n = 1'b0;
        dvld = 1'b0;
        ena = 1'b1;
        i_a = '0;
        rnd_zero = 1'b1;
        ob_xor_exp = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", {255'd0, ready}, 1);
        check("rst_ovld", {255'd0, ovld}, 0);
        check("rst_ob", o_b, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {255'd0, ready}, 1);

        // Basic conversion with rnd held at zero.
        issue(shares_for(32'h12345678), LAT, a1);
        wait_empty();
        check("basic_value", {224'd0, xor_shares(o_b)}, {224'd0, 32'h12345678});

        // Wrap-around of the modular sum.
        rnd_zero = 1'b0;
        v = '0;
        v[31:0]  = 32'hFFFF_FFFF;
        v[63:32] = 32'h0000_0001;
        issue(v, LAT, a1);
        wait_empty();
        check("wrap_value", {224'd0, xor_shares(o_b)}, 0);

        // Ten cycles of stall in the middle of an ADD phase.
        issue(shares_for(32'hCAFE_F00D), LAT + 10, a1);
        repeat (20) @(negedge clk);
        ena = 1'b0;
        repeat (10) @(negedge clk);
        ena = 1'b1;
        wait_empty();

        // dvld while busy must be ignored.
        issue(shares_for(32'h0BAD_BEEF), LAT, a1);
        repeat (49) @(negedge clk);
        i_a  = rand_shares();
        dvld = 1'b1;
        check("busy_ready", {255'd0, ready}, 0);
        @(negedge clk);
        dvld = 1'b0;
        wait_empty();
        check("busy_value", {224'd0, xor_shares(o_b)}, {224'd0, 32'h0BAD_BEEF});

        // Reset in the middle of a conversion.
        issue(shares_for(32'h5555_AAAA), LAT, a1);
        repeat (99) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        ob_xor_exp = '0;
        @(negedge clk);
        check("midrst_ovld", {255'd0, ovld}, 0);
        check("midrst_ob", o_b, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_ready", {255'd0, ready}, 1);
        issue(shares_for(32'h7777_1234), LAT, a1);
        wait_empty();

        // Back-to-back transactions with ena held high.
        issue(rand_shares(), LAT, a1);
        issue(rand_shares(), LAT, a2);
        check("b2b_period", (K*N)'(a2 - a1), (K*N)'(LAT + 2));
        wait_empty();

        // Randomized shares and randomness.
        for (int t = 0; t < 150; t++) begin
            rnd_zero = ($urandom_range(0, 3) == 0);
            issue(rand_shares(), LAT, a1);
            wait_empty();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
